// File: rtl/indicator_pkg.sv
// rtl/indicator_pkg.sv - shared LED count and ASCII command codes
package indicator_pkg;

    localparam int NUM_LEDS = 5;

    localparam logic [7:0] CMD_CLEAR    = 8'h30;
    localparam logic [7:0] CMD_DIGIT_LO = 8'h31;
    localparam logic [7:0] CMD_DIGIT_HI = 8'h35;
    localparam logic [7:0] CMD_SET_U    = 8'h41;
    localparam logic [7:0] CMD_SET_L    = 8'h61;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_TOGGLE,
        OP_CLEAR,
        OP_SET
    } led_op_e;

    function automatic led_op_e decode_cmd(input logic [7:0] cmd);
        if (cmd >= CMD_DIGIT_LO && cmd <= CMD_DIGIT_HI) begin
            return OP_TOGGLE;
        end else if (cmd == CMD_CLEAR) begin
            return OP_CLEAR;
        end else if (cmd == CMD_SET_U || cmd == CMD_SET_L) begin
            return OP_SET;
        end
        return OP_NONE;
    endfunction

endpackage

// File: rtl/ready_edge.sv
// rtl/ready_edge.sv - rising-edge detector on the ready strobe, one-cycle accept pulse
module ready_edge (
    input  logic clk,
    input  logic rst,
    input  logic ready,
    output logic accept
);

    logic ready_q;
    logic ready_d;

    always_comb begin
        ready_d = ready;
    end

    // Resetting to 1 keeps a ready already high at reset release from counting as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign accept = ready & ~ready_q;

endmodule

// File: rtl/led_indicator.sv
// rtl/led_indicator.sv - decodes ASCII command bytes into toggle/clear/set of five LEDs
module led_indicator
    import indicator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    output logic [4:0] leds
);

    logic                accept;
    logic [NUM_LEDS-1:0] led_q;
    logic [NUM_LEDS-1:0] led_d;
    logic [2:0]          led_idx;
    led_op_e             op;

    ready_edge u_ready_edge (
        .clk    (clk),
        .rst    (rst),
        .ready  (ready),
        .accept (accept)
    );

    // Digit n maps to bit 5-n, which is simply CMD_DIGIT_HI minus the byte.
    always_comb begin
        op      = decode_cmd(data);
        led_idx = 3'(CMD_DIGIT_HI - data);
        led_d   = led_q;
        if (accept) begin
            case (op)
                OP_TOGGLE: led_d[led_idx] = ~led_q[led_idx];
                OP_CLEAR:  led_d = '0;
                OP_SET:    led_d = '1;
                default:   led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign leds = led_q;

endmodule

// File: tb/tb_led_indicator.sv
// tb/tb_led_indicator.sv - scoreboard bench for led_indicator with directed command vectors
module tb_led_indicator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;
    logic [4:0] leds;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [4:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];

    led_indicator dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .ready (ready),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: each entry is due at the negedge following the posedge it names.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                sb_item_t it;
                it = sb.pop_front();
                checks++;
                if (leds !== it.exp || it.cyc != cyc) begin
                    failures++;
                    $display("FAIL %s: leds=%b required=%b (cycle %0d, due %0d)",
                             it.name, leds, it.exp, cyc, it.cyc);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [7:0] d, input logic [4:0] exp,
                        input string name);
        @(posedge clk);
        #1;
        ready = r;
        data  = d;
        sb.push_back('{cyc + 1, exp, name});
    endtask

    initial begin
        #1;
        checks++;
        if (leds !== 5'b00000) begin
            failures++;
            $display("FAIL reset_state: leds=%b required=00000", leds);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 5'b00000, "idle");
        for (int i = 0; i < 5; i++)   step(1'b0, 8'h31, 5'b00000, "pre_strobe");

        step(1'b1, 8'h31, 5'b10000, "cmd_1");
        step(1'b0, 8'h32, 5'b10000, "low");
        step(1'b1, 8'h32, 5'b11000, "cmd_2a");
        step(1'b0, 8'h00, 5'b11000, "low");
        step(1'b1, 8'h32, 5'b10000, "cmd_2b");
        step(1'b0, 8'h00, 5'b10000, "low");
        step(1'b1, 8'h41, 5'b11111, "cmd_A");
        step(1'b0, 8'h00, 5'b11111, "low");
        step(1'b1, 8'h30, 5'b00000, "cmd_0");
        step(1'b0, 8'h00, 5'b00000, "low");

        step(1'b1, 8'h33, 5'b00100, "cmd_3_held0");
        step(1'b1, 8'h33, 5'b00100, "cmd_3_held1");
        step(1'b1, 8'h31, 5'b00100, "cmd_3_held2");
        step(1'b1, 8'h41, 5'b00100, "cmd_3_held3");
        step(1'b0, 8'h00, 5'b00100, "low");
        step(1'b1, 8'h78, 5'b00100, "cmd_x");
        step(1'b0, 8'h00, 5'b00100, "low");
        step(1'b1, 8'h2F, 5'b00100, "cmd_slash");
        step(1'b0, 8'h00, 5'b00100, "low");
        step(1'b1, 8'h36, 5'b00100, "cmd_6");
        step(1'b0, 8'h00, 5'b00100, "low");

        step(1'b1, 8'h61, 5'b11111, "cmd_a");
        step(1'b0, 8'h00, 5'b11111, "low");
        step(1'b1, 8'h34, 5'b11101, "cmd_4");
        step(1'b0, 8'h00, 5'b11101, "low");
        step(1'b1, 8'h35, 5'b11100, "cmd_5");
        step(1'b0, 8'h00, 5'b11100, "low");
        step(1'b1, 8'h41, 5'b11111, "cmd_A2");
        step(1'b1, 8'h41, 5'b11111, "held_A2");

        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (leds !== 5'b00000) begin
            failures++;
            $display("FAIL async_reset: leds=%b required=00000", leds);
        end
        step(1'b1, 8'h35, 5'b00000, "in_reset0");
        step(1'b1, 8'h35, 5'b00000, "in_reset1");
        rst = 1'b0;
        step(1'b1, 8'h35, 5'b00000, "post_reset_high0");
        step(1'b1, 8'h35, 5'b00000, "post_reset_high1");
        step(1'b0, 8'h35, 5'b00000, "post_reset_low");
        step(1'b1, 8'h35, 5'b00001, "post_reset_cmd_5");
        step(1'b0, 8'h00, 5'b00001, "low");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
